// File: rtl/frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : frame_sequencer
//  Description : Double-buffered frame sequencer. On a frame request it
//                clears the back buffer (one zero word per cycle), starts the
//                block renderer, forwards the renderer's writes to the
//                framebuffer, then waits for vsync to swap buffers.
//                One extra request may be queued while busy; any further
//                request is discarded and reported.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                frame_req         - one-cycle request to render a frame
//                vsync             - one-cycle vertical-blank pulse
//                blocks_start      - one-cycle start pulse to the renderer
//                blocks_done       - one-cycle completion from the renderer
//                blocks_we/addr/data - renderer write port (used in DRAW)
//                fb_we/addr/data   - framebuffer write port
//                fb_sel            - back-buffer select (display uses ~fb_sel)
//                busy              - high while not idle
//                frame_done        - one-cycle pulse on buffer swap
//                req_dropped       - one-cycle pulse when a request is lost
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_sequencer #(
    parameter int DRAW_WIDTH  = 640,
    parameter int DRAW_HEIGHT = 480,
    parameter int DRAW_SIZE   = DRAW_WIDTH * DRAW_HEIGHT,
    parameter int DRAW_ADDRW  = $clog2(DRAW_SIZE),
    parameter int DRAW_DATAW  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_req,
    input  logic                  vsync,
    output logic                  blocks_start,
    input  logic                  blocks_done,
    input  logic [DRAW_ADDRW-1:0] blocks_addr,
    input  logic [DRAW_DATAW-1:0] blocks_data,
    input  logic                  blocks_we,
    output logic [DRAW_ADDRW-1:0] fb_addr,
    output logic [DRAW_DATAW-1:0] fb_data,
    output logic                  fb_we,
    output logic                  fb_sel,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  req_dropped
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_clear = 2'd1;
    localparam logic [1:0] c_st_draw  = 2'd2;
    localparam logic [1:0] c_st_wait  = 2'd3;

    // Terminal compare is against the real depth, so non-power-of-two
    // buffers stop exactly at their last word.
    localparam logic [DRAW_ADDRW-1:0] c_last_addr = DRAW_ADDRW'(DRAW_SIZE - 1);

    // The buffer cannot hold more words than the drawable area.
    if (DRAW_SIZE < 2 || DRAW_SIZE > DRAW_WIDTH * DRAW_HEIGHT) begin : g_bad_size
        $error("frame_sequencer: DRAW_SIZE out of range");
    end

    logic [1:0]            r_state;
    logic                  r_pending;
    logic [DRAW_ADDRW-1:0] r_clr_cnt;

    logic       w_clear_last;
    logic       w_wait_exit;
    logic       w_start_clear;
    logic [1:0] w_state_nxt;

    assign w_clear_last = (r_state == c_st_clear) && (r_clr_cnt == c_last_addr);
    assign w_wait_exit  = (r_state == c_st_wait) && vsync;
    // A request arriving on the swap cycle counts as if it were already
    // pending, so it starts the next frame directly.
    assign w_start_clear = ((r_state == c_st_idle) && frame_req) ||
                           (w_wait_exit && (r_pending || frame_req));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:  if (frame_req)    w_state_nxt = c_st_clear;
            c_st_clear: if (w_clear_last) w_state_nxt = c_st_draw;
            c_st_draw:  if (blocks_done)  w_state_nxt = c_st_wait;
            c_st_wait:  if (vsync)        w_state_nxt = w_start_clear ? c_st_clear : c_st_idle;
            default:                      w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_pending    <= 1'b0;
            r_clr_cnt    <= '0;
            fb_sel       <= 1'b0;
            fb_we        <= 1'b0;
            fb_addr      <= '0;
            fb_data      <= '0;
            blocks_start <= 1'b0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            req_dropped  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            busy         <= (w_state_nxt != c_st_idle);
            blocks_start <= 1'b0;
            frame_done   <= 1'b0;
            req_dropped  <= 1'b0;

            // Single-entry request queue. On the swap cycle the old entry is
            // consumed and a simultaneous request takes its place.
            if (w_wait_exit) begin
                r_pending <= r_pending & frame_req;
            end else if (frame_req && (r_state != c_st_idle)) begin
                if (r_pending) begin
                    req_dropped <= 1'b1;
                end else begin
                    r_pending <= 1'b1;
                end
            end

            case (r_state)
                c_st_clear: begin
                    if (w_clear_last) begin
                        fb_we        <= 1'b0;
                        blocks_start <= 1'b1;
                    end else begin
                        fb_we     <= 1'b1;
                        fb_addr   <= r_clr_cnt + 1'b1;
                        fb_data   <= '0;
                        r_clr_cnt <= r_clr_cnt + 1'b1;
                    end
                end
                c_st_draw: begin
                    // Renderer writes pass through unchanged, including one
                    // that coincides with blocks_done.
                    fb_we   <= blocks_we;
                    fb_addr <= blocks_addr;
                    fb_data <= blocks_data;
                end
                c_st_wait: begin
                    fb_we <= 1'b0;
                    if (vsync) begin
                        fb_sel     <= ~fb_sel;
                        frame_done <= 1'b1;
                    end
                end
                default: begin
                    fb_we <= 1'b0;
                end
            endcase

            // Entering CLEAR writes address 0 on the very next cycle.
            if (w_start_clear) begin
                fb_we     <= 1'b1;
                fb_addr   <= '0;
                fb_data   <= '0;
                r_clr_cnt <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frame_sequencer
//  Description : Self-checking bench for frame_sequencer (8x4 buffer). A
//                directed warm-up is followed by randomized stimulus; every
//                cycle the registered outputs are compared with a behavioural
//                model that describes frames as a queue of clear words.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_sequencer;

    localparam int c_w     = 8;
    localparam int c_h     = 4;
    localparam int c_size  = 32;
    localparam int c_addrw = 5;
    localparam int c_dataw = 1;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 frame_req = 1'b0;
    logic                 vsync = 1'b0;
    logic                 blocks_done = 1'b0;
    logic [c_addrw-1:0]   blocks_addr = '0;
    logic [c_dataw-1:0]   blocks_data = '0;
    logic                 blocks_we = 1'b0;
    logic                 blocks_start;
    logic [c_addrw-1:0]   fb_addr;
    logic [c_dataw-1:0]   fb_data;
    logic                 fb_we;
    logic                 fb_sel;
    logic                 busy;
    logic                 frame_done;
    logic                 req_dropped;

    frame_sequencer #(
        .DRAW_WIDTH (c_w),
        .DRAW_HEIGHT(c_h),
        .DRAW_SIZE  (c_size),
        .DRAW_ADDRW (c_addrw),
        .DRAW_DATAW (c_dataw)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .frame_req   (frame_req),
        .vsync       (vsync),
        .blocks_start(blocks_start),
        .blocks_done (blocks_done),
        .blocks_addr (blocks_addr),
        .blocks_data (blocks_data),
        .blocks_we   (blocks_we),
        .fb_addr     (fb_addr),
        .fb_data     (fb_data),
        .fb_we       (fb_we),
        .fb_sel      (fb_sel),
        .busy        (busy),
        .frame_done  (frame_done),
        .req_dropped (req_dropped)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum int {M_IDLE, M_CLEAR, M_DRAW, M_WAIT} mode_t;
    mode_t              m_mode = M_IDLE;
    bit                 m_pend = 1'b0;
    int                 clr_q[$];
    logic               e_we = 1'b0, e_sel = 1'b0, e_start = 1'b0, e_done = 1'b0, e_drop = 1'b0;
    logic [c_addrw-1:0] e_addr = '0;
    logic [c_dataw-1:0] e_data = '0;
    bit                 e_chk_ad = 1'b0;

    task automatic emit_clear();
        e_we   = 1'b1;
        e_addr = c_addrw'(clr_q.pop_front());
        e_data = '0;
    endtask

    task automatic begin_frame();
        m_mode = M_CLEAR;
        clr_q.delete();
        for (int i = 0; i < c_size; i++) clr_q.push_back(i);
        emit_clear();
    endtask

    // Predict the outputs that follow the coming clock edge.
    task automatic model_edge();
        bit wait_exit;
        if (rst) begin
            m_mode = M_IDLE; m_pend = 1'b0; e_sel = 1'b0;
            e_we = 1'b0; e_addr = '0; e_data = '0;
            e_start = 1'b0; e_done = 1'b0; e_drop = 1'b0; e_chk_ad = 1'b1;
            clr_q.delete();
        end else begin
            e_chk_ad = 1'b0; e_start = 1'b0; e_done = 1'b0; e_drop = 1'b0;
            wait_exit = (m_mode == M_WAIT) && vsync;
            if (!wait_exit && m_mode != M_IDLE && frame_req) begin
                if (m_pend) e_drop = 1'b1;
                else        m_pend = 1'b1;
            end
            case (m_mode)
                M_IDLE: begin
                    e_we = 1'b0;
                    if (frame_req) begin_frame();
                end
                M_CLEAR: begin
                    if (clr_q.size() == 0) begin
                        m_mode = M_DRAW; e_start = 1'b1; e_we = 1'b0;
                    end else begin
                        emit_clear();
                    end
                end
                M_DRAW: begin
                    e_we = blocks_we; e_addr = blocks_addr; e_data = blocks_data;
                    if (blocks_done) m_mode = M_WAIT;
                end
                default: begin
                    e_we = 1'b0;
                    if (vsync) begin
                        e_sel  = ~e_sel;
                        e_done = 1'b1;
                        if (m_pend || frame_req) begin
                            m_pend = m_pend && frame_req;
                            begin_frame();
                        end else begin
                            m_mode = M_IDLE;
                        end
                    end
                end
            endcase
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_val("fb_we", 32'(fb_we), 32'(e_we));
        check_val("busy", 32'(busy), 32'(m_mode != M_IDLE));
        check_val("fb_sel", 32'(fb_sel), 32'(e_sel));
        check_val("frame_done", 32'(frame_done), 32'(e_done));
        check_val("req_dropped", 32'(req_dropped), 32'(e_drop));
        check_val("blocks_start", 32'(blocks_start), 32'(e_start));
        if (e_we || e_chk_ad) begin
            check_val("fb_addr", 32'(fb_addr), 32'(e_addr));
            check_val("fb_data", 32'(fb_data), 32'(e_data));
        end
    endtask

    task automatic quiet();
        rst = 1'b0; frame_req = 1'b0; vsync = 1'b0;
        blocks_done = 1'b0; blocks_we = 1'b0;
    endtask

    initial begin
        // Reset, then idle with stray vsync / renderer activity.
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step();
        quiet();
        for (int i = 0; i < 6; i++) begin
            blocks_we   = 1'b1;
            blocks_addr = c_addrw'($urandom_range(0, c_size - 1));
            blocks_data = c_dataw'($urandom);
            vsync       = (i == 2);
            blocks_done = (i == 4);
            step();
        end
        quiet();
        frame_req = 1'b1; step();
        frame_req = 1'b0;
        // Three extra requests during CLEAR: one queued, two dropped.
        for (int i = 0; i < 40 && m_mode != M_DRAW; i++) begin
            frame_req = (i == 2 || i == 5 || i == 8);
            step();
        end
        quiet();
        // DRAW: stray vsync, a write at 17, then done with a coincident write.
        for (int i = 0; i < 3; i++) step();
        vsync = 1'b1; step(); vsync = 1'b0;
        blocks_we = 1'b1; blocks_addr = 5'd17; blocks_data = 1'b1; step();
        blocks_we = 1'b0; step();
        blocks_we = 1'b1; blocks_addr = 5'd3; blocks_data = 1'b1; blocks_done = 1'b1; step();
        quiet();
        for (int i = 0; i < 4; i++) step();
        vsync = 1'b1; step(); vsync = 1'b0;
        // Pending request restarts CLEAR; reset it mid-way at address 20.
        for (int i = 0; i < 40 && !(m_mode == M_CLEAR && e_addr == 5'd20); i++) step();
        rst = 1'b1; step(); rst = 1'b0;
        blocks_done = 1'b1; step(); blocks_done = 1'b0;
        for (int i = 0; i < 3; i++) step();

        // Randomized traffic.
        for (int i = 0; i < 5000; i++) begin
            rst         = ($urandom_range(0, 599) == 0);
            frame_req   = ($urandom_range(0, 24) == 0);
            vsync       = ($urandom_range(0, 5) == 0);
            blocks_done = ($urandom_range(0, 14) == 0);
            blocks_we   = $urandom_range(0, 1) == 1;
            blocks_addr = c_addrw'($urandom_range(0, c_size - 1));
            blocks_data = c_dataw'($urandom);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/frame_sequencer.md
FRAME_SEQUENCER -- requirements
Module: frame_sequencer

Interface
REQ-001 SHALL have parameter DRAW_WIDTH, default 640, meaning framebuffer width in pixels.
REQ-002 SHALL have parameter DRAW_HEIGHT, default 480, meaning framebuffer height in pixels.
REQ-003 SHALL have parameter DRAW_SIZE, default DRAW_WIDTH*DRAW_HEIGHT, meaning framebuffer depth in words.
REQ-004 SHALL have parameter DRAW_ADDRW, default $clog2(DRAW_SIZE), meaning framebuffer address width.
REQ-005 SHALL have parameter DRAW_DATAW, default 1, meaning framebuffer word width.
REQ-006 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst, input, 1, the synchronous active-high reset.
REQ-008 SHALL have port frame_req, input, 1, a one-cycle request to render one frame.
REQ-009 SHALL have port vsync, input, 1, a one-cycle vertical-blank pulse from video timing.
REQ-010 SHALL have port blocks_start, output, 1, a one-cycle start pulse to the block renderer.
REQ-011 SHALL have port blocks_done, input, 1, a one-cycle completion pulse from the block renderer.
REQ-012 SHALL have port blocks_addr, input, DRAW_ADDRW, the renderer write address.
REQ-013 SHALL have port blocks_data, input, DRAW_DATAW, the renderer write data.
REQ-014 SHALL have port blocks_we, input, 1, the renderer write enable.
REQ-015 SHALL have port fb_addr, output, DRAW_ADDRW, the framebuffer write address.
REQ-016 SHALL have port fb_data, output, DRAW_DATAW, the framebuffer write data.
REQ-017 SHALL have port fb_we, output, 1, the framebuffer write enable.
REQ-018 SHALL have port fb_sel, output, 1, the back-buffer select; display reads buffer ~fb_sel.
REQ-019 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-020 SHALL have port frame_done, output, 1, a one-cycle pulse on buffer swap.
REQ-021 SHALL have port req_dropped, output, 1, a one-cycle pulse when a request is discarded.

Function
REQ-022 SHALL use states IDLE, CLEAR, DRAW and WAIT_VSYNC.
REQ-023 All outputs SHALL be registered.
REQ-024 IDLE: frame_req sampled at cycle t SHALL enter CLEAR at t+1.
REQ-025 CLEAR: fb_we=1, fb_data=0, fb_addr=0..DRAW_SIZE-1 SHALL appear on DRAW_SIZE consecutive cycles starting at t+1, one address per cycle, with no gaps.
REQ-026 The cycle after the write to address DRAW_SIZE-1, the block SHALL enter DRAW and assert blocks_start for exactly 1 cycle.
REQ-027 DRAW: blocks_we/addr/data sampled at cycle n SHALL appear on fb_we/addr/data at n+1 (one-cycle forwarding, unmodified).
REQ-028 blocks_we outside DRAW SHALL be ignored; fb_we SHALL be 0 in IDLE and WAIT_VSYNC.
REQ-029 blocks_done sampled in DRAW SHALL enter WAIT_VSYNC next cycle; a write sampled in the same cycle as blocks_done SHALL still be forwarded.
REQ-030 blocks_done outside DRAW SHALL be ignored.
REQ-031 vsync SHALL be sampled only in WAIT_VSYNC; vsync in other states SHALL have no effect.
REQ-032 vsync sampled in WAIT_VSYNC at cycle v SHALL, at v+1, toggle fb_sel and pulse frame_done for 1 cycle.
REQ-033 At v+1 the state SHALL be CLEAR if a request is pending (pending then clears), else IDLE.
REQ-034 A frame_req while busy SHALL set a single pending flag if it is clear.
REQ-035 A frame_req while pending is already set SHALL pulse req_dropped the next cycle and leave pending set.
REQ-036 A frame_req in the same cycle as the WAIT_VSYNC exit SHALL be treated as pending, without a drop.
REQ-037 The clear address counter SHALL be DRAW_ADDRW wide, with its terminal compare at DRAW_SIZE-1 (non-power-of-two sizes).

Reset
REQ-038 rst sampled high SHALL, next cycle, set state=IDLE, pending=0, clear counter=0, fb_sel=0, and fb_we, blocks_start, busy, frame_done and req_dropped all 0.
REQ-039 fb_addr and fb_data SHALL reset to 0.
REQ-040 rst SHALL take priority over every other input in any state, including mid-CLEAR and mid-DRAW.
REQ-041 After reset, an in-flight renderer SHALL be ignored (REQ-028/REQ-030 apply).

Verification (DRAW_WIDTH=8, DRAW_HEIGHT=4, DRAW_SIZE=32, DRAW_ADDRW=5)
REQ-042 frame_req at cycle 10 -> fb_we=1 cycles 11..42 with addr 0..31 and data 0; blocks_start=1 at cycle 43 only.
REQ-043 In DRAW, blocks_we=1, addr=17, data=1 at cycle 50 -> fb_we=1, addr=17, data=1 at cycle 51; blocks_done at 60 -> busy=1 and fb_we=0 from 61 onward.
REQ-044 In WAIT_VSYNC, vsync at 70 -> fb_sel 0->1 and frame_done=1 at 71; busy=0 at 71.
REQ-045 Three frame_req pulses during CLEAR -> one req_dropped pulse per extra request (2 total); after the swap, CLEAR restarts at addr 0 the following cycle.
REQ-046 rst at clear address 20 -> next cycle state=IDLE and fb_we=0; a later blocks_done is ignored and busy stays 0.
REQ-047 vsync during DRAW and blocks_we during IDLE -> no fb_sel change and no fb_we.
